// File: rtl/stage_sequencer_pkg.sv
// Shared definitions for the RV32 multi-cycle stage sequencer.
// Holds the controller state encoding, the machine trap cause codes and a
// helper that maps the latched decode flags to a cause code.
package stage_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_MEM,
    ST_WRITE,
    ST_TRAP,
    ST_HALT
  } state_t;

  localparam logic [3:0] CAUSE_BREAKPOINT = 4'd3;
  localparam logic [3:0] CAUSE_ECALL_M    = 4'd11;

  // ebreak takes precedence when decode raised both flags.
  function automatic logic [3:0] trap_cause_of(input logic ecall, input logic ebreak);
    if (ebreak)     return CAUSE_BREAKPOINT;
    else if (ecall) return CAUSE_ECALL_M;
    else            return 4'd0;
  endfunction

endpackage

// File: rtl/stage_sequencer_if.sv
// Bundle between the stage sequencer and the core datapath stages.
// master: the sequencer (drives pc, stage enables, trap and retire status;
//         receives start/halt requests and decode/execute/memory results).
// slave : the datapath / environment side, mirror image of master.
interface stage_sequencer_if #(
  parameter int PC_W = 32
);
  logic            start;
  logic            halt_req;
  logic            mem_busy;
  logic            is_ecall;
  logic            is_ebreak;
  logic            is_mret;
  logic            branch_taken;
  logic [PC_W-1:0] branch_target;
  logic [PC_W-1:0] mtvec;
  logic [PC_W-1:0] mepc;

  logic [PC_W-1:0] pc;
  logic            fetch_en;
  logic            decode_en;
  logic            exec_en;
  logic            mem_en;
  logic            write_en;
  logic            trap_take;
  logic [3:0]      trap_cause;
  logic [PC_W-1:0] trap_pc;
  logic            instret;
  logic [31:0]     instret_cnt;
  logic            busy;

  modport master (
    input  start, halt_req, mem_busy, is_ecall, is_ebreak, is_mret,
           branch_taken, branch_target, mtvec, mepc,
    output pc, fetch_en, decode_en, exec_en, mem_en, write_en,
           trap_take, trap_cause, trap_pc, instret, instret_cnt, busy
  );

  modport slave (
    output start, halt_req, mem_busy, is_ecall, is_ebreak, is_mret,
           branch_taken, branch_target, mtvec, mepc,
    input  pc, fetch_en, decode_en, exec_en, mem_en, write_en,
           trap_take, trap_cause, trap_pc, instret, instret_cnt, busy
  );
endinterface

// File: rtl/stage_sequencer_pc_select.sv
// Next-PC selection used at instruction retirement.
// Priority: mret -> mepc, taken branch -> branch target, else pc + 1
// (word-indexed PC, wraps modulo 2^PC_W).
// Ports: pc, mret, mepc, br_taken, br_target in; next_pc out.
module stage_sequencer_pc_select #(
  parameter int PC_W = 32
) (
  input  logic [PC_W-1:0] pc,
  input  logic            mret,
  input  logic [PC_W-1:0] mepc,
  input  logic            br_taken,
  input  logic [PC_W-1:0] br_target,
  output logic [PC_W-1:0] next_pc
);

  always_comb begin
    next_pc = pc + PC_W'(1);
    if (mret)          next_pc = mepc;
    else if (br_taken) next_pc = br_target;
  end

endmodule

// File: rtl/stage_sequencer.sv
// Multi-cycle controller for the RV32 core. Owns the PC, steps each
// instruction through FETCH/DECODE/EXEC/MEM/WRITE by raising one stage
// enable at a time, redirects the PC on branches, traps and mret, and
// counts retired instructions.
// Ports: clk, rstn (async, active-low); bus (master modport) carrying
// start/halt_req/mem_busy, decode flags, branch result, mtvec/mepc in, and
// pc, stage enables, trap_take/cause/pc, instret/instret_cnt, busy out.
module stage_sequencer
  import stage_sequencer_pkg::*;
#(
  parameter int              PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rstn,
  stage_sequencer_if.master  bus
);

  state_t          state, state_nxt;
  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] pc_next;
  logic            ecall_q, ebreak_q, mret_q, br_taken_q;
  logic [PC_W-1:0] br_target_q;
  logic            halt_pending;
  logic [3:0]      trap_cause_q;
  logic [PC_W-1:0] trap_pc_q;
  logic [31:0]     instret_cnt_q;
  logic            halt_now;

  // A request arriving in the very cycle of an instruction boundary is
  // honoured at that boundary rather than one instruction later.
  assign halt_now = halt_pending | bus.halt_req;

  stage_sequencer_pc_select #(.PC_W(PC_W)) u_pc_select (
    .pc        (pc_q),
    .mret      (mret_q),
    .mepc      (bus.mepc),
    .br_taken  (br_taken_q),
    .br_target (br_target_q),
    .next_pc   (pc_next)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (bus.start) state_nxt = ST_FETCH;
      ST_FETCH:  state_nxt = ST_DECODE;
      ST_DECODE: state_nxt = (bus.is_ecall || bus.is_ebreak) ? ST_TRAP : ST_EXEC;
      ST_EXEC:   state_nxt = ST_MEM;
      ST_MEM:    if (!bus.mem_busy) state_nxt = ST_WRITE;
      ST_WRITE:  state_nxt = halt_now ? ST_HALT : ST_FETCH;
      ST_TRAP:   state_nxt = halt_now ? ST_HALT : ST_FETCH;
      ST_HALT:   if (bus.start) state_nxt = ST_FETCH;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state         <= ST_IDLE;
      pc_q          <= RESET_PC;
      ecall_q       <= 1'b0;
      ebreak_q      <= 1'b0;
      mret_q        <= 1'b0;
      br_taken_q    <= 1'b0;
      br_target_q   <= '0;
      halt_pending  <= 1'b0;
      trap_cause_q  <= 4'd0;
      trap_pc_q     <= '0;
      instret_cnt_q <= 32'd0;
    end else begin
      state <= state_nxt;

      if (state_nxt == ST_HALT)  halt_pending <= 1'b0;
      else if (bus.halt_req)     halt_pending <= 1'b1;

      // Per-instruction latches start clean on every fetch.
      if (state_nxt == ST_FETCH) begin
        ecall_q     <= 1'b0;
        ebreak_q    <= 1'b0;
        mret_q      <= 1'b0;
        br_taken_q  <= 1'b0;
        br_target_q <= '0;
      end else if (state == ST_DECODE) begin
        ecall_q  <= bus.is_ecall;
        ebreak_q <= bus.is_ebreak;
        mret_q   <= bus.is_mret;
      end else if (state == ST_EXEC) begin
        br_taken_q  <= bus.branch_taken;
        br_target_q <= bus.branch_target;
      end

      if (state == ST_WRITE) begin
        pc_q          <= pc_next;
        instret_cnt_q <= instret_cnt_q + 32'd1;
      end else if (state == ST_TRAP) begin
        trap_cause_q <= trap_cause_of(ecall_q, ebreak_q);
        trap_pc_q    <= pc_q;
        pc_q         <= bus.mtvec;
      end
    end
  end

  assign bus.pc          = pc_q;
  assign bus.fetch_en    = (state == ST_FETCH);
  assign bus.decode_en   = (state == ST_DECODE);
  assign bus.exec_en     = (state == ST_EXEC);
  assign bus.mem_en      = (state == ST_MEM);
  assign bus.write_en    = (state == ST_WRITE);
  assign bus.trap_take   = (state == ST_TRAP);
  assign bus.instret     = (state == ST_WRITE);
  assign bus.trap_cause  = trap_cause_q;
  assign bus.trap_pc     = trap_pc_q;
  assign bus.instret_cnt = instret_cnt_q;
  assign bus.busy        = (state != ST_IDLE) && (state != ST_HALT);

endmodule

// File: tb/tb_stage_sequencer.sv
// Testbench for stage_sequencer (PC_W=6 so PC wrap is reachable).
// A driver issues instructions (directed then random); for each one the
// expected architectural outcome is pushed into a queue and a monitor pops
// it when the DUT retires or traps.
module tb_stage_sequencer;
  localparam int PC_W = 6;
  localparam int PC_MOD = 64;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  stage_sequencer_if #(.PC_W(PC_W)) bus();

  stage_sequencer #(.PC_W(PC_W), .RESET_PC(6'd0)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  typedef struct {
    bit          trap;
    bit          halt;
    logic [31:0] pc_cur;
    logic [31:0] pc_next;
    logic [31:0] cnt;
    logic [31:0] cause;
    logic [31:0] tpc;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  bit   mon_on  = 1'b0;

  // reference architectural state
  int          m_pc    = 0;
  logic [31:0] m_cnt   = 32'd0;
  int          m_cause = 0;
  int          m_tpc   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (mon_on) begin
        chk("enables_onehot0", 32'($onehot0({bus.fetch_en, bus.decode_en, bus.exec_en,
                                             bus.mem_en, bus.write_en})), 32'd1);
        if (bus.instret || bus.trap_take) begin
          if (q.size() == 0) begin
            chk("unexpected_event", 32'd1, 32'd0);
          end else begin
            e = q.pop_front();
            chk("event_is_trap", 32'(bus.trap_take), 32'(e.trap));
            chk("event_is_retire", 32'(bus.instret), 32'(!e.trap));
            chk("pc_at_event", 32'(bus.pc), e.pc_cur);
            @(negedge clk);
            chk("pc_after", 32'(bus.pc), e.pc_next);
            chk("instret_cnt", bus.instret_cnt, e.cnt);
            chk("trap_cause", 32'(bus.trap_cause), e.cause);
            chk("trap_pc", 32'(bus.trap_pc), e.tpc);
            chk("pulse_cleared", 32'(bus.instret | bus.trap_take), 32'd0);
            if (e.halt) chk("halt_busy", 32'(bus.busy), 32'd0);
            else        chk("fetch_next", 32'(bus.fetch_en), 32'd1);
          end
        end
      end
    end
  end

  task automatic run_instr(input bit ec, input bit eb, input bit mr, input bit br,
                           input int tgt, input int tv, input int ep,
                           input int w, input bit h, input bit noise);
    int   guard;
    int   k;
    exp_t e;
    guard = 0;
    while (!bus.fetch_en && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!bus.fetch_en) begin
      chk("fetch_wait_timeout", 32'(bus.fetch_en), 32'd1);
      return;
    end
    e.trap   = ec | eb;
    e.halt   = h;
    e.pc_cur = 32'(m_pc);
    if (e.trap) begin
      m_cause = eb ? 3 : 11;
      m_tpc   = m_pc;
      m_pc    = tv;
    end else begin
      if (mr)      m_pc = ep;
      else if (br) m_pc = tgt;
      else         m_pc = (m_pc + 1) % PC_MOD;
      m_cnt = m_cnt + 1;
    end
    e.pc_next = 32'(m_pc);
    e.cnt     = m_cnt;
    e.cause   = 32'(m_cause);
    e.tpc     = 32'(m_tpc);
    q.push_back(e);

    bus.is_ecall      = ec;
    bus.is_ebreak     = eb;
    bus.is_mret       = mr;
    bus.branch_taken  = br;
    bus.branch_target = PC_W'(tgt);
    bus.mtvec         = PC_W'(tv);
    bus.mepc          = PC_W'(ep);
    bus.mem_busy      = 1'($urandom % 2);
    bus.halt_req      = 1'b0;
    bus.start         = 1'b0;

    @(negedge clk);
    chk("decode_en", 32'(bus.decode_en), 32'd1);
    bus.halt_req = h;
    @(negedge clk);
    bus.halt_req = 1'b0;
    bus.start    = noise;
    if (e.trap) begin
      chk("trap_follows_decode", 32'(bus.trap_take), 32'd1);
      @(negedge clk);
      bus.start = 1'b0;
    end else begin
      chk("exec_en", 32'(bus.exec_en), 32'd1);
      @(negedge clk);
      bus.start = 1'b0;
      k = 0;
      while (bus.mem_en && k < 40) begin
        k++;
        bus.mem_busy = (k <= w);
        @(negedge clk);
      end
      chk("mem_cycles", 32'(k), 32'(w + 1));
      chk("write_en", 32'(bus.write_en), 32'd1);
      @(negedge clk);
    end
    if (h) begin
      repeat ($urandom_range(1, 4)) @(negedge clk);
      chk("halt_stays_idle", 32'(bus.busy), 32'd0);
      chk("halt_pc", 32'(bus.pc), 32'(m_pc));
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
    end
  endtask

  initial begin
    bit ec, eb, mr, br, h, nz;
    rstn              = 1'b0;
    bus.start         = 1'b0;
    bus.halt_req      = 1'b0;
    bus.mem_busy      = 1'b0;
    bus.is_ecall      = 1'b0;
    bus.is_ebreak     = 1'b0;
    bus.is_mret       = 1'b0;
    bus.branch_taken  = 1'b0;
    bus.branch_target = '0;
    bus.mtvec         = '0;
    bus.mepc          = '0;

    repeat (3) @(negedge clk);
    chk("rst_pc", 32'(bus.pc), 32'd0);
    chk("rst_enables", 32'({bus.fetch_en, bus.decode_en, bus.exec_en, bus.mem_en, bus.write_en}), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_trap_take", 32'(bus.trap_take), 32'd0);
    chk("rst_trap_cause", 32'(bus.trap_cause), 32'd0);
    chk("rst_trap_pc", 32'(bus.trap_pc), 32'd0);
    chk("rst_instret", 32'(bus.instret), 32'd0);
    chk("rst_instret_cnt", bus.instret_cnt, 32'd0);

    rstn = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_without_start", 32'(bus.busy), 32'd0);
    mon_on    = 1'b1;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;

    // directed: ecall/ebreak/mret/branch/wrap/halt cases
    run_instr(0, 0, 0, 0,  0,  0,  0, 0, 0, 0);  // 0 -> 1
    run_instr(0, 0, 0, 0,  0,  0,  0, 3, 0, 1);  // 1 -> 2, MEM held 3 cycles
    run_instr(0, 0, 0, 1,  8,  0,  0, 0, 0, 0);  // branch -> 8
    run_instr(1, 0, 0, 0,  0, 47,  0, 0, 0, 0);  // ecall at 8 -> 47
    run_instr(0, 0, 0, 1,  4,  0,  0, 1, 0, 0);  // branch -> 4
    run_instr(1, 1, 0, 0,  0, 10,  0, 0, 0, 1);  // both flags at 4 -> breakpoint
    run_instr(0, 0, 1, 1, 30,  0,  5, 0, 0, 0);  // mret beats branch -> 5
    run_instr(0, 0, 0, 1, 63,  0,  0, 0, 0, 0);  // -> 63
    run_instr(0, 0, 0, 0,  0,  0,  0, 2, 0, 0);  // 63 wraps to 0
    run_instr(0, 0, 0, 1, 20,  0,  0, 0, 0, 0);  // -> 20
    run_instr(0, 0, 0, 1, 12,  0,  0, 0, 0, 0);  // 20 -> 12
    run_instr(0, 0, 0, 0,  0,  0,  0, 0, 1, 0);  // 12 -> 13 then HALT
    run_instr(1, 0, 0, 0,  0, 33,  0, 0, 1, 0);  // trap then HALT

    for (int i = 0; i < 300; i++) begin
      ec = ($urandom % 8) == 0;
      eb = ($urandom % 8) == 0;
      mr = ($urandom % 8) == 0;
      br = ($urandom % 3) == 0;
      h  = ($urandom % 10) == 0;
      nz = ($urandom % 4) == 0;
      run_instr(ec, eb, mr, br, int'($urandom % PC_MOD), int'($urandom % PC_MOD),
                int'($urandom % PC_MOD), int'($urandom % 4), h, nz);
    end

    // asynchronous reset in the middle of MEM
    repeat (3) @(negedge clk);
    mon_on = 1'b0;
    chk("queue_drained", 32'(q.size()), 32'd0);
    bus.is_ecall     = 1'b0;
    bus.is_ebreak    = 1'b0;
    bus.branch_taken = 1'b0;
    bus.mem_busy     = 1'b1;
    begin
      int guard;
      guard = 0;
      while (!bus.mem_en && guard < 20) begin
        @(negedge clk);
        guard++;
      end
    end
    chk("reached_mem", 32'(bus.mem_en), 32'd1);
    #2 rstn = 1'b0;
    #1;
    chk("async_rst_pc", 32'(bus.pc), 32'd0);
    chk("async_rst_mem_en", 32'(bus.mem_en), 32'd0);
    chk("async_rst_busy", 32'(bus.busy), 32'd0);
    chk("async_rst_cnt", bus.instret_cnt, 32'd0);
    chk("async_rst_trap_pc", 32'(bus.trap_pc), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
